// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding req/gnt/rvalid fetcher feeding id_stage through an
// output register plus a one-entry skid buffer, with redirect killing buffered/in-flight words.
module if_stage #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        stall,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [29:0] if_pc,
  output logic        if_valid
);

  localparam logic [31:0] NopInst = 32'h00000013;

  typedef enum logic {StReq, StWait} state_e;

  state_e      state_q;
  logic [29:0] pc_q;
  logic [29:0] fpc_q;
  logic        discard_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [29:0] out_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_inst_q;
  logic [29:0] skid_pc_q;
  logic        resp_ok;

  // A new request is only issued with the skid free, so a returning word always has a slot.
  assign imem_req  = rst_l && (state_q == StReq) && !skid_valid_q;
  assign imem_addr = pc_q;
  assign inst      = out_valid_q ? out_inst_q : NopInst;
  assign if_pc     = out_pc_q;
  assign if_valid  = out_valid_q;

  assign resp_ok = (state_q == StWait) && imem_rvalid && !discard_q && !redirect;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      fpc_q        <= RESET_PC;
      discard_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= NopInst;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NopInst;
      skid_pc_q    <= RESET_PC;
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_req && imem_gnt) begin
            state_q   <= StWait;
            fpc_q     <= pc_q;
            pc_q      <= redirect ? redirect_pc : pc_q + 30'd1;
            discard_q <= redirect;
          end else if (redirect) begin
            pc_q <= redirect_pc;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_q   <= StReq;
            discard_q <= 1'b0;
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
          if (redirect) pc_q <= redirect_pc;
        end
        default: state_q <= StReq;
      endcase

      if (redirect) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!stall) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_inst_q   <= skid_inst_q;
          out_pc_q     <= skid_pc_q;
          skid_valid_q <= resp_ok;
          if (resp_ok) begin
            skid_inst_q <= imem_rdata;
            skid_pc_q   <= fpc_q;
          end
        end else if (resp_ok) begin
          out_valid_q <= 1'b1;
          out_inst_q  <= imem_rdata;
          out_pc_q    <= fpc_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (resp_ok) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_inst_q  <= imem_rdata;
          out_pc_q    <= fpc_q;
        end else begin
          skid_valid_q <= 1'b1;
          skid_inst_q  <= imem_rdata;
          skid_pc_q    <= fpc_q;
        end
      end
    end
  end

endmodule
